// File: rtl/rs232_transceiver_if.sv
// Serial pin pair plus the byte-wide strobe handshakes of the UART.
// The slave modport is the transceiver; the master modport is whatever
// drives it (fabric logic, or a testbench).
interface rs232_transceiver_if;
  logic       rx;
  logic       tx;
  logic [7:0] rx_data;
  logic       rx_data_clk;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       tx_data_clk;

  modport master (
    output rx, tx_data, tx_en,
    input  tx, rx_data, rx_data_clk, tx_data_clk
  );

  modport slave (
    input  rx, tx_data, tx_en,
    output tx, rx_data, rx_data_clk, tx_data_clk
  );
endinterface

// File: rtl/rs232_transceiver.sv
// Full-duplex 8N1 UART: an independent receiver and transmitter sharing clk.
// PERIOD is clocks per bit; the receiver samples HALF_PERIOD into the start
// bit and then every PERIOD, i.e. mid-bit.
module rs232_transceiver #(
  parameter int PERIOD      = 1250,
  parameter int HALF_PERIOD = PERIOD / 2
) (
  input logic                clk,
  input logic                rst,
  rs232_transceiver_if.slave bus
);
  localparam int              CW        = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0]   BIT_LAST  = CW'(PERIOD - 1);
  localparam logic [CW-1:0]   HALF_LAST = CW'(HALF_PERIOD - 1);

  // ------------------------------------------------------------------
  // Receiver (rs232_recv)
  // ------------------------------------------------------------------
  // RX_BREAK holds off start detection after a framing error until the
  // line has returned high, so a held-low line is not read as a frame.
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  rx_state_t     rx_state;
  logic          rx_meta, rxs;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shreg;
  logic [7:0]    rx_data_q;
  logic          rx_strobe;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rxs     <= rx_meta;
    end
  end

  // Receive FSM: detect start, confirm at half bit, sample mid-bit, check stop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_shreg  <= '0;
      rx_data_q <= '0;
      rx_strobe <= 1'b0;
    end else begin
      rx_strobe <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (!rxs) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            // A line already back high at mid start bit was a glitch.
            rx_state <= rxs ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shreg <= {rxs, rx_shreg[7:1]};
            rx_bit   <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            if (rxs) begin
              rx_data_q <= rx_shreg;
              rx_strobe <= 1'b1;
              // Back to IDLE at mid stop bit so an early next start is caught.
              rx_state  <= RX_IDLE;
            end else begin
              rx_state  <= RX_BREAK;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_BREAK: begin
          rx_cnt <= '0;
          if (rxs) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  assign bus.rx_data     = rx_data_q;
  assign bus.rx_data_clk = rx_strobe;

  // ------------------------------------------------------------------
  // Transmitter (rs232_send)
  // ------------------------------------------------------------------
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shreg;
  logic          tx_q;
  logic          tx_strobe;

  // Transmit FSM: the line level is registered, so tx changes one edge after
  // the decision and goes high asynchronously with rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shreg  <= '0;
      tx_q      <= 1'b1;
      tx_strobe <= 1'b0;
    end else begin
      tx_strobe <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          tx_q   <= 1'b1;
          tx_cnt <= '0;
          if (bus.tx_en) begin
            tx_shreg  <= bus.tx_data;
            tx_strobe <= 1'b1;
            tx_q      <= 1'b0;
            tx_state  <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_q     <= tx_shreg[0];
            tx_shreg <= {1'b0, tx_shreg[7:1]};
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            tx_bit <= tx_bit + 1'b1;
            if (tx_bit == 3'd7) begin
              tx_q     <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_q     <= tx_shreg[0];
              tx_shreg <= {1'b0, tx_shreg[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            // Chain straight into the next frame when more data is waiting.
            if (bus.tx_en) begin
              tx_shreg  <= bus.tx_data;
              tx_strobe <= 1'b1;
              tx_q      <= 1'b0;
              tx_state  <= TX_START;
            end else begin
              tx_state  <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  assign bus.tx          = tx_q;
  assign bus.tx_data_clk = tx_strobe;

endmodule

// File: tb/tb_rs232_transceiver.sv
// Directed + randomized bench for rs232_transceiver. A line sniffer decodes tx
// frames by mid-bit sampling and monitors collect strobes; the main initial
// block drives stimulus and compares against expected byte lists.
module tb_rs232_transceiver;
  localparam int P   = 50;
  localparam int H   = P / 2;
  localparam int LAT = 2 + H + 9 * P;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic loop = 1'b0;
  logic rx_drv = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  logic [7:0] rx_got[$];
  int         rx_cyc[$];
  int         rx_start[$];
  int         txp_cyc[$];
  logic [9:0] tx_frames[$];
  int         tx_start[$];

  rs232_transceiver_if bus();
  assign bus.rx = loop ? bus.tx : rx_drv;

  rs232_transceiver #(.PERIOD(P)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitors, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.rx_data_clk === 1'b1) begin
      rx_got.push_back(bus.rx_data);
      rx_cyc.push_back(cyc);
    end
    if (bus.tx_data_clk === 1'b1) txp_cyc.push_back(cyc);
  end

  // tx line sniffer: stores {stop, data, start} sampled at mid-bit.
  initial begin : tx_sniff
    logic [9:0] f;
    int t0;
    forever begin
      @(negedge bus.tx);
      t0 = cyc;
      repeat (H) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
        f[i] = bus.tx;
        if (i < 9) repeat (P) @(negedge clk);
      end
      tx_frames.push_back(f);
      tx_start.push_back(t0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one frame; caller is aligned just after a posedge, and so is the
  // return, which lets consecutive calls run back-to-back.
  task automatic rx_frame(input logic [7:0] b, input logic stop_bit, input int per);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      if (i == 0) rx_start.push_back(cyc);
      repeat (per) @(posedge clk);
      #1;
    end
    rx_drv = 1'b1;
  endtask

  task automatic wait_rx(input int n, input int budget);
    for (int i = 0; i < budget && rx_got.size() < n; i++) @(negedge clk);
    chk("rx_count", rx_got.size(), n);
  endtask

  task automatic wait_txp(input int n, input int budget);
    for (int i = 0; i < budget && txp_cyc.size() < n; i++) @(negedge clk);
    chk("txp_count", txp_cyc.size(), n);
  endtask

  task automatic check_rx(input string tag, input logic [7:0] exp_q[$]);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < rx_got.size()) begin
        chk(tag, rx_got[i], exp_q[i]);
        chk("rx_latency",
            ((rx_cyc[i] - rx_start[i] >= LAT - 1) && (rx_cyc[i] - rx_start[i] <= LAT + 1)), 1);
      end
    end
  endtask

  initial begin : main
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int dev_tx, dev_st, dev_d, n;

    bus.tx_en = 1'b0;
    bus.tx_data = 8'h00;

    // ---- reset state and quiet idle
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_tx", bus.tx, 1);
    chk("rst_txclk", bus.tx_data_clk, 0);
    chk("rst_rxclk", bus.rx_data_clk, 0);
    chk("rst_rxdata", bus.rx_data, 8'h00);
    dev_tx = 0; dev_st = 0; dev_d = 0;
    repeat (20 * P) begin
      @(negedge clk);
      if (bus.tx !== 1'b1) dev_tx++;
      if (bus.tx_data_clk !== 1'b0 || bus.rx_data_clk !== 1'b0) dev_st++;
      if (bus.rx_data !== 8'h00) dev_d++;
    end
    chk("idle_tx", dev_tx, 0);
    chk("idle_strobes", dev_st, 0);
    chk("idle_rxdata", dev_d, 0);

    // ---- back-to-back transmit 00, FF, AA; A5 must never go out
    bus.tx_en = 1'b1;
    @(negedge clk);
    chk("tx_lat_line", bus.tx, 0);
    chk("tx_lat_strobe", bus.tx_data_clk, 1);
    bus.tx_data = 8'hFF;
    wait_txp(2, 11 * P);
    bus.tx_data = 8'hAA;
    wait_txp(3, 11 * P);
    bus.tx_data = 8'hA5;
    bus.tx_en = 1'b0;
    repeat (12 * P) @(negedge clk);
    chk("txp_total", txp_cyc.size(), 3);
    if (txp_cyc.size() == 3) begin
      chk("txp_gap1", txp_cyc[1] - txp_cyc[0], 10 * P);
      chk("txp_gap2", txp_cyc[2] - txp_cyc[1], 10 * P);
    end
    chk("tx_frames", tx_frames.size(), 3);
    exp_q = '{8'h00, 8'hFF, 8'hAA};
    for (int i = 0; i < 3 && i < tx_frames.size(); i++) begin
      chk("tx_frame", tx_frames[i], {1'b1, exp_q[i], 1'b0});
      if (i > 0) chk("tx_spacing", tx_start[i] - tx_start[i-1], 10 * P);
    end
    chk("tx_idle_after", bus.tx, 1);

    // ---- receive "1".."5" back-to-back at nominal rate
    rx_got.delete(); rx_cyc.delete(); rx_start.delete();
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    @(posedge clk); #1;
    foreach (exp_q[i]) rx_frame(exp_q[i], 1'b1, P);
    wait_rx(5, 12 * P);
    check_rx("rx_ascii", exp_q);

    // ---- short low glitch is ignored, then 0x55 is received
    rx_got.delete(); rx_cyc.delete(); rx_start.delete();
    @(posedge clk); #1;
    rx_drv = 1'b0;
    repeat (10) @(posedge clk);
    #1 rx_drv = 1'b1;
    repeat (2 * P) @(posedge clk);
    #1;
    chk("glitch_nopulse", rx_got.size(), 0);
    chk("glitch_hold", bus.rx_data, 8'h35);
    exp_q = '{8'h55};
    rx_frame(8'h55, 1'b1, P);
    wait_rx(1, 12 * P);
    check_rx("rx_after_glitch", exp_q);

    // ---- framing error: A5 with low stop, line held low, then 0x3C
    rx_got.delete(); rx_cyc.delete(); rx_start.delete();
    @(posedge clk); #1;
    rx_frame(8'hA5, 1'b0, P);
    rx_drv = 1'b0;
    repeat (2 * P) @(posedge clk);
    #1 rx_drv = 1'b1;
    repeat (2 * P) @(posedge clk);
    #1;
    chk("ferr_nopulse", rx_got.size(), 0);
    chk("ferr_hold", bus.rx_data, 8'h55);
    rx_start.delete();
    exp_q = '{8'h3C};
    rx_frame(8'h3C, 1'b1, P);
    wait_rx(1, 12 * P);
    check_rx("rx_after_ferr", exp_q);

    // ---- random bytes at nominal and +/-2% bit rates
    rx_got.delete(); rx_cyc.delete(); rx_start.delete();
    exp_q.delete();
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom_range(255));
      exp_q.push_back(b);
      rx_frame(b, 1'b1, P - 1 + int'($urandom_range(2)));
    end
    wait_rx(8, 12 * P);
    for (int i = 0; i < 8 && i < rx_got.size(); i++) chk("rx_random", rx_got[i], exp_q[i]);

    // ---- loopback 00, 5A, FF plus random bytes
    rx_got.delete(); rx_cyc.delete(); rx_start.delete(); txp_cyc.delete();
    loop = 1'b1;
    exp_q = '{8'h00, 8'h5A, 8'hFF};
    for (int i = 0; i < 3; i++) exp_q.push_back(8'($urandom_range(255)));
    @(negedge clk);
    bus.tx_data = exp_q[0];
    bus.tx_en = 1'b1;
    for (int i = 1; i <= exp_q.size(); i++) begin
      wait_txp(i, 11 * P);
      if (i < exp_q.size()) bus.tx_data = exp_q[i];
    end
    bus.tx_en = 1'b0;
    wait_rx(exp_q.size(), 12 * P);
    for (int i = 0; i < exp_q.size() && i < rx_got.size(); i++) chk("loopback", rx_got[i], exp_q[i]);

    // ---- reset mid-frame: tx high at once, aborted byte never reported
    repeat (2 * P) @(negedge clk);
    n = rx_got.size();
    bus.tx_data = 8'h00;
    bus.tx_en = 1'b1;
    @(negedge clk);
    bus.tx_en = 1'b0;
    repeat (3 * P) @(negedge clk);
    chk("abort_pre_tx", bus.tx, 0);
    #2 rst = 1'b1;
    #1 chk("abort_tx_async", bus.tx, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12 * P) @(negedge clk);
    chk("abort_nopulse", rx_got.size(), n);
    chk("abort_rxdata", bus.rx_data, 8'h00);
    chk("abort_tx_idle", bus.tx, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
